// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: opcode type and opcode encodings.
package alu_pkg;

    typedef logic [1:0] alu_op_t;

    localparam alu_op_t OP_ADD = 2'b00;
    localparam alu_op_t OP_SUB = 2'b01;
    localparam alu_op_t OP_AND = 2'b10;
    localparam alu_op_t OP_OR  = 2'b11;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: next result and status flags from operands and opcode.
import alu_pkg::*;

module alu_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          ALUCtrl,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             zero,
    output logic             ovf
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Widened add and subtract; subtraction as a + ~b + 1 so bit WIDTH is the no-borrow flag.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    end

    // Opcode decode; unknown codes fall back to ADD so nothing X leaks into the registers.
    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (ALUCtrl)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res   = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: begin
                res = a & b;
            end
            OP_OR: begin
                res = a | b;
            end
            default: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
        endcase
        zero = (res == '0);
    end

endmodule

// File: rtl/alu.sv
// Registered ALU: one-cycle latency, result/flags hold when no valid input.
import alu_pkg::*;

module alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          ALUCtrl,
    input  logic             in_valid,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             zero,
    output logic             ovf,
    output logic             out_valid
);

    logic [WIDTH-1:0] res_next;
    logic             carry_next;
    logic             zero_next;
    logic             ovf_next;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a       (a),
        .b       (b),
        .ALUCtrl (ALUCtrl),
        .res     (res_next),
        .carry   (carry_next),
        .zero    (zero_next),
        .ovf     (ovf_next)
    );

    // Output registers: reset wins, valid inputs load, otherwise result and flags hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            res       <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                res   <= res_next;
                carry <= carry_next;
                zero  <= zero_next;
                ovf   <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: vector table, hand sequences and a strided operand sweep.
import alu_pkg::*;

module tb_alu;

    typedef struct packed {
        logic [7:0] res;
        logic       carry;
        logic       zero;
        logic       ovf;
    } exp_t;

    typedef struct {
        alu_op_t    op;
        logic [7:0] a;
        logic [7:0] b;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    alu_op_t    ALUCtrl;
    logic       in_valid;
    logic [7:0] res;
    logic       carry;
    logic       zero;
    logic       ovf;
    logic       out_valid;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t last;
    vec_t vt[11];

    alu #(
        .WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .ALUCtrl   (ALUCtrl),
        .in_valid  (in_valid),
        .res       (res),
        .carry     (carry),
        .zero      (zero),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference model built from integer arithmetic and signed range checks.
    function automatic exp_t model(input alu_op_t op, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int ux, uy, sx, sy, r, s;
        ux = int'(x);
        uy = int'(y);
        sx = x[7] ? ux - 256 : ux;
        sy = y[7] ? uy - 256 : uy;
        e  = '0;
        r  = 0;
        case (op)
            OP_ADD: begin
                r = ux + uy; s = sx + sy;
                e.carry = (r > 255);
                e.ovf   = (s > 127) || (s < -128);
            end
            OP_SUB: begin
                r = ux - uy; s = sx - sy;
                e.carry = (ux >= uy);
                e.ovf   = (s > 127) || (s < -128);
            end
            OP_AND: r = ux & uy;
            default: r = ux | uy;
        endcase
        e.res  = r[7:0];
        e.zero = (e.res == 8'h00);
        return e;
    endfunction

    function automatic vec_t mk(input alu_op_t op, input logic [7:0] x, input logic [7:0] y,
                                input logic [7:0] r, input logic c, input logic z, input logic v);
        vec_t t;
        t.op = op; t.a = x; t.b = y;
        t.e.res = r; t.e.carry = c; t.e.zero = z; t.e.ovf = v;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            if (failures <= 50)
                $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // One clock: drive inputs, push expectation when a valid op is accepted, then check after the edge.
    task automatic cycle(input logic r, input logic v, input alu_op_t op,
                         input logic [7:0] x, input logic [7:0] y, input exp_t e);
        exp_t got;
        rst = r; in_valid = v; ALUCtrl = op; a = x; b = y;
        if (v && !r) sb.push_back(e);
        @(posedge clk);
        #1;
        if (r) begin
            sb.delete();
            last = '0;
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_res", 32'(res), 32'd0);
            chk("rst_flags", {29'd0, carry, zero, ovf}, 32'd0);
        end else begin
            chk("out_valid", 32'(out_valid), 32'(v));
            if (v) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    got = sb.pop_front();
                    chk("res", 32'(res), 32'(got.res));
                    chk("carry", 32'(carry), 32'(got.carry));
                    chk("zero", 32'(zero), 32'(got.zero));
                    chk("ovf", 32'(ovf), 32'(got.ovf));
                    last = got;
                end
            end else begin
                chk("hold_res", 32'(res), 32'(last.res));
                chk("hold_flags", {29'd0, carry, zero, ovf}, {29'd0, last.carry, last.zero, last.ovf});
            end
        end
    endtask

    initial begin
        vt[0]  = mk(OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
        vt[1]  = mk(OP_ADD, 8'd100, 8'd50, 8'd150, 1'b0, 1'b0, 1'b1);
        vt[2]  = mk(OP_SUB, 8'd5, 8'd7, 8'hFE, 1'b0, 1'b0, 1'b0);
        vt[3]  = mk(OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1);
        vt[4]  = mk(OP_AND, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0);
        vt[5]  = mk(OP_OR,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0);
        vt[6]  = mk(OP_SUB, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b0, 1'b1);
        vt[7]  = mk(OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1);
        vt[8]  = mk(OP_SUB, 8'h33, 8'h33, 8'h00, 1'b1, 1'b1, 1'b0);
        vt[9]  = mk(OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
        vt[10] = mk(OP_AND, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);

        rst = 1'b1; in_valid = 1'b1; ALUCtrl = OP_ADD; a = 8'hFF; b = 8'h01;
        last = '0;

        // Reset held two cycles with a valid op presented; it must be discarded.
        cycle(1'b1, 1'b1, OP_ADD, 8'hFF, 8'h01, '0);
        cycle(1'b1, 1'b1, OP_ADD, 8'hFF, 8'h01, '0);
        cycle(1'b0, 1'b0, OP_ADD, 8'hFF, 8'h01, '0);
        cycle(1'b0, 1'b1, OP_ADD, 8'h12, 8'h34, model(OP_ADD, 8'h12, 8'h34));

        // Directed vectors with hand-derived expectations.
        foreach (vt[i])
            cycle(1'b0, 1'b1, vt[i].op, vt[i].a, vt[i].b, vt[i].e);

        // Back-to-back one per opcode, then idle cycles must hold the last result.
        cycle(1'b0, 1'b1, OP_ADD, 8'h40, 8'h41, model(OP_ADD, 8'h40, 8'h41));
        cycle(1'b0, 1'b1, OP_SUB, 8'h10, 8'h20, model(OP_SUB, 8'h10, 8'h20));
        cycle(1'b0, 1'b1, OP_AND, 8'hAA, 8'h3C, model(OP_AND, 8'hAA, 8'h3C));
        cycle(1'b0, 1'b1, OP_OR,  8'hA0, 8'h05, model(OP_OR,  8'hA0, 8'h05));
        cycle(1'b0, 1'b0, OP_ADD, 8'h01, 8'h01, '0);
        cycle(1'b0, 1'b0, OP_SUB, 8'h00, 8'h00, '0);

        // Reset mid-stream: the op alongside reset is lost, first post-reset valid is next output.
        cycle(1'b0, 1'b1, OP_SUB, 8'h09, 8'h03, model(OP_SUB, 8'h09, 8'h03));
        cycle(1'b1, 1'b1, OP_ADD, 8'h7F, 8'h7F, '0);
        cycle(1'b0, 1'b0, OP_ADD, 8'h7F, 8'h7F, '0);
        cycle(1'b0, 1'b1, OP_OR,  8'h00, 8'h00, model(OP_OR, 8'h00, 8'h00));

        // Strided sweep: every a against 16 b values including 0 and 255, all opcodes.
        for (int unsigned op = 0; op < 4; op++)
            for (int unsigned x = 0; x < 256; x++)
                for (int unsigned y = 0; y < 256; y += 17)
                    cycle(1'b0, 1'b1, alu_op_t'(op), 8'(x), 8'(y),
                          model(alu_op_t'(op), 8'(x), 8'(y)));

        cycle(1'b0, 1'b0, OP_ADD, 8'h00, 8'h00, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
